// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared frame-buffer definitions: scan-controller state
//               encoding and the memory geometry defaults.
// Revision    : 1.0
// ============================================================================
package fb_pkg;

    localparam int FB_DATA_WIDTH = 16;
    localparam int FB_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fb_state_t;

endpackage
`default_nettype wire

// File: rtl/fb_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fb_pix_fifo
// Description : Show-ahead synchronous FIFO buffering returned pixel words.
// Revision    : 1.0
// ============================================================================
module fb_pix_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int            c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && (r_count != c_depth);
    assign w_pop_ok  = i_pop  && (r_count != '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fb_rd_scan.sv
`default_nettype none
// ============================================================================
// Module      : fb_rd_scan
// Description : Frame-buffer read scanner: sweeps the memory once per start
//               and streams the words out with valid/ready backpressure.
// Revision    : 1.0
// ============================================================================
module fb_rd_scan
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_DATA_WIDTH,
    parameter int ADDR_WIDTH = FB_ADDR_WIDTH,
    parameter int FRAME_LEN  = 2**ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int                    c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(FRAME_LEN - 1);
    localparam logic [c_cnt_w:0]      c_depth     = (c_cnt_w + 1)'(FIFO_DEPTH);
    localparam bit                    c_single    = (FRAME_LEN == 1);

    fb_state_t             r_state;
    fb_state_t             w_state_next;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_issue_addr;
    logic                  r_last1;
    logic                  r_v2;
    logic                  r_last2;
    logic                  w_empty;
    logic [DATA_WIDTH:0]   w_head;
    logic [c_cnt_w-1:0]    w_count;
    logic [c_cnt_w:0]      w_load;
    logic                  w_credit_ok;
    logic                  w_pop;
    logic                  w_final_pop;

    // Every read already issued will land in the FIFO, so count it as used.
    assign w_load      = {1'b0, w_count} + (c_cnt_w + 1)'(mem_rd_en)
                       + (c_cnt_w + 1)'(r_v2);
    assign w_credit_ok = (w_load < c_depth);

    assign pix_valid   = ~w_empty;
    assign pix_data    = pix_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign pix_last    = pix_valid & w_head[DATA_WIDTH];
    assign busy        = (r_state != IDLE);
    assign w_pop       = pix_valid & pix_ready;
    assign w_final_pop = (r_state == DRAIN) && w_pop && pix_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // mem_rd_addr doubles as the sweep counter: it always holds the last
    // address issued, and loads 0 on the start edge.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_issue_addr = mem_rd_addr;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_issue      = 1'b1;
                    w_issue_addr = '0;
                end
            end
            RUN: begin
                if (c_single) begin
                    w_state_next = DRAIN;
                end else if (w_credit_ok) begin
                    w_issue      = 1'b1;
                    w_issue_addr = mem_rd_addr + 1'b1;
                    if (w_issue_addr == c_last_addr) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_final_pop) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            r_last1     <= 1'b0;
            r_v2        <= 1'b0;
            r_last2     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            mem_rd_en <= w_issue;
            if (w_issue) begin
                mem_rd_addr <= w_issue_addr;
                r_last1     <= (w_issue_addr == c_last_addr);
            end
            r_v2       <= mem_rd_en;
            r_last2    <= r_last1;
            frame_done <= w_final_pop;
        end
    end

    fb_pix_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (r_v2),
        .i_push_data ({r_last2, mem_rd_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fb_rd_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_fb_rd_scan
// Description : Scoreboard bench for fb_rd_scan (8-word and 1-word frames).
// Revision    : 1.0
// ============================================================================
module tb_fb_rd_scan;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          pix_ready = 1'b1;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] pix_data;
    logic          pix_valid, pix_last, busy, frame_done;

    logic          start_s = 1'b0;
    logic          ready_s = 1'b1;
    logic          en_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] rdata_s;
    logic [DW-1:0] data_s;
    logic          valid_s, last_s, busy_s, done_s;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW:0]   exp_q[$];
    logic [DW:0]   mon_e;
    int            issued = 0;
    int            accepted = 0;
    logic          pv, pr, prst, plast;
    logic [DW-1:0] pdata;
    int            pat[4] = '{1, 0, 0, 1};

    always #5 clk = ~clk;

    fb_rd_scan #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
    );

    fb_rd_scan #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset(reset), .start(start_s),
        .mem_rd_en(en_s), .mem_rd_addr(addr_s), .mem_rd_data(rdata_s),
        .pix_data(data_s), .pix_valid(valid_s), .pix_ready(ready_s),
        .pix_last(last_s), .busy(busy_s), .frame_done(done_s)
    );

    // Memory models: mem[i] = 0x0010 + i, one-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 16'h0010 + 16'(mem_rd_addr);
        if (en_s)      rdata_s     <= 16'h0010 + 16'(addr_s);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (frame_done !== 1'b1 && n < max) begin
            tick();
            n++;
        end
    endtask

    task automatic push_frame();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), 16'h0010 + 16'(i)});
    endtask

    // Monitor: scoreboard pops, stall stability and outstanding-read bound.
    always @(negedge clk) begin
        if (!reset) begin
            issued   = 0;
            accepted = 0;
        end else begin
            if (prst && pv && !pr) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_word", {pix_last, pix_data}, {plast, pdata});
            end
            if (mem_rd_en) begin
                issued++;
                chk("credit_bound", (issued - accepted) <= 4, 1);
            end
            if (pix_valid && pix_ready) begin
                accepted++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %0h, expected none", pix_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pix_data", pix_data, mon_e[DW-1:0]);
                    chk("pix_last", pix_last, mon_e[DW]);
                end
            end
        end
        pv    = pix_valid;
        pr    = pix_ready;
        prst  = reset;
        pdata = pix_data;
        plast = pix_last;
    end

    initial begin
        int            n;
        int            cnt;
        int            k;
        logic [AW-1:0] last_a;
        logic          seen;

        // Reset state
        repeat (2) tick();
        chk("reset_outputs", {mem_rd_en, mem_rd_addr, pix_valid, pix_last, busy, frame_done, pix_data}, 0);
        chk("reset_outputs_s", {en_s, addr_s, valid_s, last_s, busy_s, done_s, data_s}, 0);
        reset = 1'b1;
        tick();

        // Full-rate frame
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_first_issue", {mem_rd_en, mem_rd_addr, busy}, {1'b1, 3'd0, 1'b1});
        tick();
        chk("t1_valid_e1", pix_valid, 0);
        tick();
        chk("t1_valid_e2", {pix_valid, pix_last, pix_data}, {1'b1, 1'b0, 16'h0010});
        wait_done(30, n);
        chk("t1_done_latency", n, 8);
        chk("t1_busy_after", busy, 0);
        chk("t1_sb_empty", exp_q.size(), 0);
        tick();

        // Ready pattern 1,0,0,1
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            pix_ready = (pat[k % 4] != 0);
            k++;
            tick();
            n++;
        end
        chk("t2_done_in_time", n < 100, 1);
        chk("t2_sb_empty", exp_q.size(), 0);
        pix_ready = 1'b1;
        tick();

        // Consumer stalled for 20 cycles
        push_frame();
        pix_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cnt = (mem_rd_en === 1'b1) ? 1 : 0;
        last_a = mem_rd_addr;
        repeat (19) begin
            tick();
            if (mem_rd_en === 1'b1) begin
                cnt++;
                last_a = mem_rd_addr;
            end
        end
        chk("t3_reads_issued", cnt, 4);
        chk("t3_last_addr", last_a, 3);
        chk("t3_rd_en_paused", mem_rd_en, 0);
        chk("t3_head_held", {pix_valid, pix_data}, {1'b1, 16'h0010});
        pix_ready = 1'b1;
        n = 0;
        while (mem_rd_en !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("t3_resume_addr", {mem_rd_en, mem_rd_addr}, {1'b1, 3'd4});
        wait_done(30, n);
        chk("t3_done", frame_done, 1);
        chk("t3_sb_empty", exp_q.size(), 0);
        tick();

        // Start while busy is ignored
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(20, n);
        chk("t4_done_latency", n, 3);
        seen = 1'b0;
        repeat (4) begin
            tick();
            seen = seen | mem_rd_en | pix_valid | busy;
        end
        chk("t4_start_ignored", seen, 0);
        chk("t4_sb_empty", exp_q.size(), 0);
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_restart_addr", {mem_rd_en, mem_rd_addr}, {1'b1, 3'd0});
        wait_done(30, n);
        chk("t4_restart_latency", n, 10);
        chk("t4_restart_sb_empty", exp_q.size(), 0);
        tick();

        // Reset while words are in flight
        pix_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("t5_after_reset", {pix_valid, busy, mem_rd_en}, 0);
        pix_ready = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            tick();
            seen = seen | pix_valid;
        end
        chk("t5_no_stale", seen, 0);
        push_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t5_first_word", {pix_valid, pix_data}, {1'b1, 16'h0010});
        wait_done(30, n);
        chk("t5_done_latency", n, 8);
        chk("t5_sb_empty", exp_q.size(), 0);
        tick();

        // Single-word frame
        ready_s = 1'b1;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        chk("t6_issue", {en_s, addr_s, busy_s}, {1'b1, 3'd0, 1'b1});
        tick();
        chk("t6_valid_e1", valid_s, 0);
        tick();
        chk("t6_word", {valid_s, last_s, data_s}, {1'b1, 1'b1, 16'h0010});
        tick();
        chk("t6_done", {done_s, valid_s, busy_s}, {1'b1, 1'b0, 1'b0});
        tick();
        chk("t6_idle", {done_s, busy_s, en_s}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fb_rd_scan.md
Name: fb_rd_scan

Overview:
- Read-side scan controller placed directly downstream of the frame-buffer data memory (data_mem_alt).
- On a start pulse it sweeps mem_rd_addr 0..FRAME_LEN-1, accounting for the memory's one-cycle read latency, and buffers returned words.
- It presents the words as an in-order pixel stream with valid/ready backpressure to the display/output stage.

Parameters:
- DATA_WIDTH, 16, pixel/memory word width; must match data_mem_alt.
- ADDR_WIDTH, 3, memory address width; must match data_mem_alt.
- FRAME_LEN, 2**ADDR_WIDTH, words per frame; legal range 1..2**ADDR_WIDTH.
- FIFO_DEPTH, 4, output buffer entries; power of two, minimum 4.

Ports:
- clk, in, 1, single clock; all state updates on the rising edge.
- reset, in, 1, synchronous active-low reset (0 = reset), sampled on rising clk.
- start, in, 1, one-cycle frame request pulse; sampled only in IDLE.
- mem_rd_en, out, 1, read strobe to the memory rd_en (active-high, registered).
- mem_rd_addr, out, ADDR_WIDTH, read address to the memory rd_addr (registered).
- mem_rd_data, in, DATA_WIDTH, memory rd_data; valid the cycle after a cycle with mem_rd_en=1.
- pix_data, out, DATA_WIDTH, head-of-buffer pixel.
- pix_valid, out, 1, pix_data is valid.
- pix_ready, in, 1, consumer accepts when pix_valid and pix_ready are both 1 at an edge.
- pix_last, out, 1, qualifies pix_data as word FRAME_LEN-1 of the frame.
- busy, out, 1, high in RUN or DRAIN.
- frame_done, out, 1, one-cycle pulse when the final word has been accepted.

Behaviour:
- Reset (reset=0 at an edge):
  - state=IDLE, addr counter=0, in-flight pipeline cleared.
  - FIFO emptied.
  - Outputs: mem_rd_en=0, mem_rd_addr=0, pix_valid=0, pix_last=0, busy=0, frame_done=0, pix_data=0.
  - Reset mid-frame abandons the frame. Words already in flight are discarded and never appear on pix_data.
- States:
  - IDLE -> RUN: when start=1. Address counter loads 0.
  - RUN -> DRAIN: on the edge that issues address FRAME_LEN-1.
  - DRAIN -> IDLE: on the edge where the last word is accepted (pix_valid & pix_ready & pix_last). frame_done pulses for the cycle after that edge.
  - start while busy is ignored, with no queuing.
- Issue rule (RUN):
  - mem_rd_en is registered high for exactly one cycle per address, with mem_rd_addr = counter. Counter increments by 1.
  - A read is issued only if occupancy + in_flight < FIFO_DEPTH, with in_flight <= 2. This never overflows the FIFO, regardless of pix_ready.
  - mem_rd_addr holds its last value when mem_rd_en=0.
- Return path:
  - A 2-stage valid shift (mem_rd_en, then memory register) tags returning data.
  - Tagged mem_rd_data is pushed into the FIFO at the edge after the memory's output cycle.
  - Latency: start sampled at edge E0 -> mem_rd_en=1/addr 0 after E0 -> rd_data after E1 -> pushed at E2 -> pix_valid=1 after E2.
- Throughput: with pix_ready held at 1, one pixel per cycle is sustained after the initial latency. A FRAME_LEN frame finishes within FRAME_LEN+3 cycles of start.
- Backpressure:
  - pix_data, pix_valid and pix_last stay stable while pix_valid=1 and pix_ready=0.
  - Push and pop can occur in the same cycle; occupancy is then unchanged.
- pix_last travels in the FIFO alongside the data: tag = (issued addr == FRAME_LEN-1).
- FRAME_LEN=1 edge case: IDLE -> RUN -> DRAIN after one issue. pix_valid and pix_last rise together.
- No address wrap within a frame. The counter never exceeds FRAME_LEN-1 and reloads to 0 only on the next start.

Decomposition:
- Shared package fb_pkg holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2);
  - DATA_WIDTH/ADDR_WIDTH defaults, shared with data_mem_alt and its write-side neighbour.
- One sub-module: fb_pix_fifo, a synchronous FIFO.
  - Width DATA_WIDTH+1 (data plus last flag), depth FIFO_DEPTH.
  - push/pop/occupancy interface, same clk and reset.
  - Show-ahead output, reset to empty.

Test Plan:
- Memory model preloaded with mem[i]=16'h0010+i, FRAME_LEN=8, pix_ready=1, start pulse: pix_data 0010..0017 on consecutive cycles; first pix_valid 3 edges after start; pix_last only with 0017; frame_done one cycle after 0017 accepted.
- Same frame, pix_ready toggled 1,0,0,1 repeating: all 8 words in order with no loss or duplication; outputs stable during stalls; FIFO occupancy never exceeds 4; mem_rd_en pauses when credits are exhausted.
- pix_ready=0 for 20 cycles after start: exactly 4 reads issued (addr 0..3), then mem_rd_en=0; releasing pix_ready resumes at addr 4.
- start pulsed again mid-frame (after word 0013): ignored; after frame_done, a new start re-reads from addr 0.
- reset=0 for one cycle while words are in flight: the next cycle shows pix_valid=0, busy=0, mem_rd_en=0; no stale word is emitted; a subsequent start delivers 0010 first.
- FRAME_LEN=1: a single word 0010 with pix_valid=pix_last=1; frame_done follows its acceptance; busy low afterward.
